// File: rtl/mem_backend_responder_pkg.sv
// Shared types and default geometry for the tag-cache memory backend responder.
package mem_backend_responder_pkg;

  localparam int unsigned MemAddrWidth    = 26;
  localparam int unsigned MemTagWidth     = 5;
  localparam int unsigned MemDataWidth    = 128;
  localparam int unsigned MemDataBeats    = 4;
  localparam int unsigned MemDepthLog2Def = 10;
  localparam int unsigned MemReadLatency  = 4;

  typedef struct packed {
    logic [MemAddrWidth-1:0] addr;
    logic [MemTagWidth-1:0]  tag;
    logic                    rw;
  } mem_cmd_t;

  typedef struct packed {
    logic [MemDataWidth-1:0] data;
    logic [MemTagWidth-1:0]  tag;
  } mem_resp_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WRITE,
    ST_RD_WAIT,
    ST_RD_RESP
  } resp_state_e;

endpackage

// File: rtl/mem_backend_responder_if.sv
// MemReqCMD / MemData / MemResp bundle between the tag cache (master) and the memory responder (slave).
interface mem_backend_responder_if #(
  parameter int unsigned AddrWidth = mem_backend_responder_pkg::MemAddrWidth,
  parameter int unsigned TagWidth  = mem_backend_responder_pkg::MemTagWidth,
  parameter int unsigned DataWidth = mem_backend_responder_pkg::MemDataWidth
) ();

  logic                 mem_cmd_valid;
  logic                 mem_cmd_ready;
  logic [AddrWidth-1:0] mem_cmd_addr;
  logic [TagWidth-1:0]  mem_cmd_tag;
  logic                 mem_cmd_rw;
  logic                 mem_data_valid;
  logic                 mem_data_ready;
  logic [DataWidth-1:0] mem_data_bits;
  logic                 mem_resp_valid;
  logic                 mem_resp_ready;
  logic [DataWidth-1:0] mem_resp_data;
  logic [TagWidth-1:0]  mem_resp_tag;

  modport master (
    output mem_cmd_valid, mem_cmd_addr, mem_cmd_tag, mem_cmd_rw,
    output mem_data_valid, mem_data_bits, mem_resp_ready,
    input  mem_cmd_ready, mem_data_ready, mem_resp_valid, mem_resp_data, mem_resp_tag
  );

  modport slave (
    input  mem_cmd_valid, mem_cmd_addr, mem_cmd_tag, mem_cmd_rw,
    input  mem_data_valid, mem_data_bits, mem_resp_ready,
    output mem_cmd_ready, mem_data_ready, mem_resp_valid, mem_resp_data, mem_resp_tag
  );

endinterface

// File: rtl/mem_backend_responder_array.sv
// 1R1W synchronous line store, one-cycle registered read; contents are not reset.
module mem_backend_responder_array #(
  parameter int unsigned AddrBits  = 12,
  parameter int unsigned DataWidth = 128
) (
  input  logic                 clk,
  input  logic                 we,
  input  logic [AddrBits-1:0]  waddr,
  input  logic [DataWidth-1:0] wdata,
  input  logic [AddrBits-1:0]  raddr,
  output logic [DataWidth-1:0] rdata
);

  logic [DataWidth-1:0] store [2**AddrBits];

  always_ff @(posedge clk) begin
    if (we) begin
      store[waddr] <= wdata;
    end
    rdata <= store[raddr];
  end

endmodule

// File: rtl/mem_backend_responder.sv
// Memory-side responder: absorbs line writes into a local store and returns tagged read beats
// after a fixed latency, one transaction in flight.
module mem_backend_responder
  import mem_backend_responder_pkg::*;
#(
  parameter int unsigned AddrWidth    = MemAddrWidth,
  parameter int unsigned TagWidth     = MemTagWidth,
  parameter int unsigned DataWidth    = MemDataWidth,
  parameter int unsigned DataBeats    = MemDataBeats,
  parameter int unsigned MemDepthLog2 = MemDepthLog2Def,
  parameter int unsigned ReadLatency  = MemReadLatency
) (
  input  logic                    clk,
  input  logic                    reset,
  mem_backend_responder_if.slave  mem
);

  localparam int unsigned BeatW = $clog2(DataBeats);
  localparam int unsigned LatW  = $clog2(ReadLatency + 1);
  localparam int unsigned RamAw = MemDepthLog2 + BeatW;

  resp_state_e              state, state_nxt;
  logic                     live_q;
  logic [MemDepthLog2-1:0]  index_q;
  logic [TagWidth-1:0]      tag_q;
  logic [BeatW-1:0]         beat_q, beat_nxt;
  logic [LatW-1:0]          lat_q, lat_nxt;
  logic                     cmd_ready, data_ready, resp_valid, cmd_fire, ram_we;
  logic [RamAw-1:0]         ram_waddr, ram_raddr;
  logic [DataWidth-1:0]     ram_rdata;
  logic                     unused_addr_bits;

  assign unused_addr_bits = ^mem.mem_cmd_addr;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= ST_IDLE;
      live_q  <= 1'b0;
      index_q <= '0;
      tag_q   <= '0;
      beat_q  <= '0;
      lat_q   <= '0;
    end else begin
      state   <= state_nxt;
      live_q  <= 1'b1;
      beat_q  <= beat_nxt;
      lat_q   <= lat_nxt;
      if (cmd_fire) begin
        index_q <= mem.mem_cmd_addr[MemDepthLog2-1:0];
        tag_q   <= mem.mem_cmd_tag;
      end
    end
  end

  always_comb begin
    state_nxt  = state;
    beat_nxt   = beat_q;
    lat_nxt    = lat_q;
    cmd_ready  = 1'b0;
    data_ready = 1'b0;
    resp_valid = 1'b0;
    cmd_fire   = 1'b0;
    ram_we     = 1'b0;
    case (state)
      ST_IDLE: begin
        // live_q keeps cmd_ready low while reset is held, even though the FSM already sits in IDLE
        cmd_ready = live_q;
        if (live_q && mem.mem_cmd_valid) begin
          cmd_fire = 1'b1;
          beat_nxt = '0;
          if (mem.mem_cmd_rw) begin
            state_nxt = ST_WRITE;
          end else begin
            state_nxt = ST_RD_WAIT;
            lat_nxt   = LatW'(ReadLatency - 1);
          end
        end
      end
      ST_WRITE: begin
        data_ready = 1'b1;
        if (mem.mem_data_valid) begin
          ram_we   = 1'b1;
          beat_nxt = beat_q + 1'b1;
          if (beat_q == BeatW'(DataBeats - 1)) state_nxt = ST_IDLE;
        end
      end
      ST_RD_WAIT: begin
        if (lat_q == '0) state_nxt = ST_RD_RESP;
        else             lat_nxt   = lat_q - 1'b1;
      end
      ST_RD_RESP: begin
        resp_valid = 1'b1;
        if (mem.mem_resp_ready) begin
          beat_nxt = beat_q + 1'b1;
          if (beat_q == BeatW'(DataBeats - 1)) state_nxt = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Reading at the next beat index every cycle lets the registered RAM output serve as the
  // response data register: it re-reads the same beat during a stall and advances without a bubble.
  assign ram_waddr = {index_q, beat_q};
  assign ram_raddr = {index_q, beat_nxt};

  mem_backend_responder_array #(
    .AddrBits  (RamAw),
    .DataWidth (DataWidth)
  ) u_array (
    .clk   (clk),
    .we    (ram_we),
    .waddr (ram_waddr),
    .wdata (mem.mem_data_bits),
    .raddr (ram_raddr),
    .rdata (ram_rdata)
  );

  assign mem.mem_cmd_ready  = cmd_ready;
  assign mem.mem_data_ready = data_ready;
  assign mem.mem_resp_valid = resp_valid;
  assign mem.mem_resp_data  = resp_valid ? ram_rdata : '0;
  assign mem.mem_resp_tag   = resp_valid ? tag_q : '0;

endmodule

// File: tb/tb_mem_backend_responder.sv
// Scoreboard bench for mem_backend_responder: default build plus a ReadLatency=1 build.
module tb_mem_backend_responder;
  import mem_backend_responder_pkg::*;

  typedef logic [127:0] line_t [4];

  logic        clk = 1'b0;
  logic        reset;
  int unsigned cyc = 0;
  int          n_tests = 0;
  int          n_fail = 0;
  mem_resp_t   sb[$];

  mem_backend_responder_if bus ();
  mem_backend_responder_if bus1 ();

  mem_backend_responder dut (.clk(clk), .reset(reset), .mem(bus));
  mem_backend_responder #(.ReadLatency(1)) dut1 (.clk(clk), .reset(reset), .mem(bus1));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string name, input logic [127:0] got, input logic [127:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // Every valid beat is compared with the scoreboard head; the head is only popped on handshake.
  always @(negedge clk) begin
    if (reset && bus.mem_resp_valid) begin
      if (sb.size() == 0) begin
        check_eq("resp_unexpected", 128'(bus.mem_resp_valid), '0);
      end else begin
        check_eq("resp_data", bus.mem_resp_data, sb[0].data);
        check_eq("resp_tag", 128'(bus.mem_resp_tag), 128'(sb[0].tag));
        if (bus.mem_resp_ready) void'(sb.pop_front());
      end
    end
  end

  task automatic send_cmd(input logic [25:0] a, input logic [4:0] t, input logic rw,
                          output int unsigned hs_cyc);
    int n = 0;
    bus.mem_cmd_valid = 1'b1;
    bus.mem_cmd_addr  = a;
    bus.mem_cmd_tag   = t;
    bus.mem_cmd_rw    = rw;
    while (!bus.mem_cmd_ready && n < 200) begin @(posedge clk); #1; n++; end
    check_eq("cmd_ready_wait", 128'(bus.mem_cmd_ready), 128'd1);
    @(posedge clk); #1;
    hs_cyc = cyc;
    bus.mem_cmd_valid = 1'b0;
  endtask

  task automatic write_line(input logic [25:0] a, input logic [4:0] t, input line_t d, input int nb);
    int unsigned hc;
    int n;
    send_cmd(a, t, 1'b1, hc);
    for (int b = 0; b < nb; b++) begin
      bus.mem_data_valid = 1'b1;
      bus.mem_data_bits  = d[b];
      n = 0;
      while (!bus.mem_data_ready && n < 50) begin @(posedge clk); #1; n++; end
      check_eq("data_ready_wait", 128'(bus.mem_data_ready), 128'd1);
      if (b == 1) check_eq("cmd_rdy_in_write", 128'(bus.mem_cmd_ready), '0);
      @(posedge clk); #1;
    end
    bus.mem_data_valid = 1'b0;
    if (nb == 4) check_eq("cmd_rdy_after_write", 128'(bus.mem_cmd_ready), 128'd1);
  endtask

  task automatic read_line(input logic [25:0] a, input logic [4:0] t, input line_t exp,
                           input int stall_beat, input int stall_n);
    int unsigned hc;
    int n;
    mem_resp_t e;
    for (int b = 0; b < 4; b++) begin
      e.data = exp[b];
      e.tag  = t;
      sb.push_back(e);
    end
    send_cmd(a, t, 1'b0, hc);
    n = 0;
    while (!bus.mem_resp_valid && n < 50) begin @(posedge clk); #1; n++; end
    check_eq("resp_valid_wait", 128'(bus.mem_resp_valid), 128'd1);
    check_eq("read_latency", 128'(cyc - hc), 128'd4);
    for (int b = 0; b < 4; b++) begin
      if (b == stall_beat) begin
        bus.mem_resp_ready = 1'b0;
        for (int s = 0; s < stall_n; s++) begin
          @(posedge clk); #1;
          check_eq("cmd_rdy_in_read", 128'(bus.mem_cmd_ready), '0);
        end
        bus.mem_resp_ready = 1'b1;
      end
      @(posedge clk); #1;
      if (b < 3) begin
        check_eq("no_bubble", 128'(bus.mem_resp_valid), 128'd1);
      end else begin
        check_eq("resp_done", 128'(bus.mem_resp_valid), '0);
        check_eq("cmd_rdy_after_read", 128'(bus.mem_cmd_ready), 128'd1);
      end
    end
  endtask

  line_t la, lb, lc, lx, ln, lmix, ld;

  initial begin
    int unsigned hc;
    int n;
    for (int b = 0; b < 4; b++) begin
      la[b] = {$urandom(), $urandom(), $urandom(), $urandom()};
      lb[b] = {$urandom(), $urandom(), $urandom(), $urandom()};
      lc[b] = {$urandom(), $urandom(), $urandom(), $urandom()};
      lx[b] = {$urandom(), $urandom(), $urandom(), $urandom()};
      ln[b] = {$urandom(), $urandom(), $urandom(), $urandom()};
      ld[b] = {$urandom(), $urandom(), $urandom(), $urandom()};
    end
    bus.mem_cmd_valid = 1'b0;  bus.mem_cmd_addr = '0;  bus.mem_cmd_tag = '0;  bus.mem_cmd_rw = 1'b0;
    bus.mem_data_valid = 1'b0; bus.mem_data_bits = '0; bus.mem_resp_ready = 1'b1;
    bus1.mem_cmd_valid = 1'b0; bus1.mem_cmd_addr = '0; bus1.mem_cmd_tag = '0; bus1.mem_cmd_rw = 1'b0;
    bus1.mem_data_valid = 1'b0; bus1.mem_data_bits = '0; bus1.mem_resp_ready = 1'b1;
    reset = 1'b0;

    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_cmd_ready", 128'(bus.mem_cmd_ready), '0);
    check_eq("rst_data_ready", 128'(bus.mem_data_ready), '0);
    check_eq("rst_resp_valid", 128'(bus.mem_resp_valid), '0);
    check_eq("rst_resp_data", bus.mem_resp_data, '0);
    check_eq("rst_resp_tag", 128'(bus.mem_resp_tag), '0);
    reset = 1'b1;
    @(posedge clk); #1;

    write_line(26'h10, 5'd3, la, 4);
    read_line(26'h10, 5'd7, la, -1, 0);

    // data offered while idle must not be taken
    bus.mem_data_valid = 1'b1;
    bus.mem_data_bits  = lb[0];
    check_eq("idle_data_ready", 128'(bus.mem_data_ready), '0);
    @(posedge clk); #1;
    check_eq("idle_data_ready2", 128'(bus.mem_data_ready), '0);
    bus.mem_data_valid = 1'b0;

    read_line(26'h10, 5'd9, la, 1, 3);

    write_line(26'h0005, 5'd1, lb, 4);
    write_line(26'h0405, 5'd2, lc, 4);
    read_line(26'h0005, 5'd4, lc, -1, 0);

    write_line(26'h20, 5'd5, lx, 4);
    write_line(26'h20, 5'd6, ln, 2);
    #2 reset = 1'b0;
    #1;
    check_eq("mid_rst_cmd_ready", 128'(bus.mem_cmd_ready), '0);
    check_eq("mid_rst_data_ready", 128'(bus.mem_data_ready), '0);
    check_eq("mid_rst_resp_valid", 128'(bus.mem_resp_valid), '0);
    check_eq("mid_rst_resp_data", bus.mem_resp_data, '0);
    check_eq("mid_rst_resp_tag", 128'(bus.mem_resp_tag), '0);
    repeat (2) @(posedge clk);
    #3 reset = 1'b1;
    @(posedge clk); #1;
    lmix[0] = ln[0]; lmix[1] = ln[1]; lmix[2] = lx[2]; lmix[3] = lx[3];
    read_line(26'h20, 5'd11, lmix, 2, 1);

    // ReadLatency=1 build
    bus1.mem_cmd_valid = 1'b1; bus1.mem_cmd_addr = 26'h3; bus1.mem_cmd_tag = 5'd1; bus1.mem_cmd_rw = 1'b1;
    n = 0;
    while (!bus1.mem_cmd_ready && n < 50) begin @(posedge clk); #1; n++; end
    check_eq("rl1_wr_cmd_ready", 128'(bus1.mem_cmd_ready), 128'd1);
    @(posedge clk); #1;
    bus1.mem_cmd_valid = 1'b0;
    for (int b = 0; b < 4; b++) begin
      bus1.mem_data_valid = 1'b1;
      bus1.mem_data_bits  = ld[b];
      check_eq("rl1_data_ready", 128'(bus1.mem_data_ready), 128'd1);
      @(posedge clk); #1;
    end
    bus1.mem_data_valid = 1'b0;
    bus1.mem_cmd_valid = 1'b1; bus1.mem_cmd_addr = 26'h3; bus1.mem_cmd_tag = 5'd12; bus1.mem_cmd_rw = 1'b0;
    check_eq("rl1_rd_cmd_ready", 128'(bus1.mem_cmd_ready), 128'd1);
    @(posedge clk); #1;
    hc = cyc;
    bus1.mem_cmd_valid = 1'b0;
    check_eq("rl1_not_early", 128'(bus1.mem_resp_valid), '0);
    @(posedge clk); #1;
    check_eq("rl1_latency_valid", 128'(bus1.mem_resp_valid), 128'd1);
    check_eq("rl1_latency_cycles", 128'(cyc - hc), 128'd1);
    for (int b = 0; b < 4; b++) begin
      check_eq("rl1_data", bus1.mem_resp_data, ld[b]);
      check_eq("rl1_tag", 128'(bus1.mem_resp_tag), 128'd12);
      @(posedge clk); #1;
    end
    check_eq("rl1_done", 128'(bus1.mem_resp_valid), '0);

    repeat (3) @(posedge clk);
    check_eq("sb_empty", 128'(sb.size()), '0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
